// File: rtl/rw_manager_m10_inst_seq.sv
`default_nettype none
// ============================================================================
// rw_manager_m10_inst_seq : walks the M10 instruction ROM from start_addr,
// runs up to four loop counters and hands each payload to the datapath.
// Revision: 1.0
// ============================================================================
module rw_manager_m10_inst_seq #(
    parameter int ADDR_W    = 7,
    parameter int DATA_W    = 20,
    parameter int PAYLOAD_W = 16,
    parameter int CNT_W     = 8
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [ADDR_W-1:0]      start_addr,
    input  logic [4*CNT_W-1:0]     cnt_load,
    input  logic [4*ADDR_W-1:0]    cnt_target,
    output logic [ADDR_W-1:0]      rom_rdaddress,
    input  logic [DATA_W-1:0]      rom_q,
    output logic [PAYLOAD_W-1:0]   out_payload,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_DECODE = 3'd2,
        S_ISSUE  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t                       state_q, state_d;
    logic [ADDR_W-1:0]            pc_q, pc_d;
    logic [3:0][CNT_W-1:0]        cnt_q, cnt_d;
    logic [3:0][CNT_W-1:0]        load_q, load_d;
    logic [3:0][ADDR_W-1:0]       target_q, target_d;
    logic [PAYLOAD_W-1:0]         payload_q, payload_d;
    logic [2:0]                   jsel_q, jsel_d;
    logic                         valid_q, valid_d;
    logic                         busy_q, busy_d;
    logic                         done_q, done_d;
    logic                         err_q, err_d;

    logic                         loop_sel;
    logic [1:0]                   sel_idx;
    logic [2:0]                   jsel_m1;
    logic                         word_end;
    logic [2:0]                   word_jsel;

    assign jsel_m1   = jsel_q - 3'd1;
    assign sel_idx   = jsel_m1[1:0];
    assign loop_sel  = (jsel_q != 3'd0) && (jsel_q <= 3'd4);
    assign word_end  = rom_q[DATA_W-1];
    assign word_jsel = rom_q[DATA_W-2 -: 3];

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            cnt_q     <= '0;
            load_q    <= '0;
            target_q  <= '0;
            payload_q <= '0;
            jsel_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            load_q    <= load_d;
            target_q  <= target_d;
            payload_q <= payload_d;
            jsel_q    <= jsel_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        cnt_d     = cnt_q;
        load_d    = load_q;
        target_d  = target_q;
        payload_d = payload_q;
        jsel_d    = jsel_q;
        valid_d   = valid_q;
        busy_d    = busy_q;
        done_d    = done_q;
        err_d     = err_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    pc_d     = start_addr;
                    cnt_d    = cnt_load;
                    load_d   = cnt_load;
                    target_d = cnt_target;
                    done_d   = 1'b0;
                    err_d    = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (word_end) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    payload_d = rom_q[PAYLOAD_W-1:0];
                    jsel_d    = word_jsel;
                    valid_d   = 1'b1;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    if (loop_sel && (cnt_q[sel_idx] != '0)) begin
                        cnt_d[sel_idx] = cnt_q[sel_idx] - 1'b1;
                        pc_d           = target_q[sel_idx];
                        state_d        = S_WAIT;
                    end else begin
                        // Reload on loop exit so an enclosing loop restarts this one
                        if (loop_sel) begin
                            cnt_d[sel_idx] = load_q[sel_idx];
                        end
                        if (&pc_q) begin
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            err_d   = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            pc_d    = pc_q + 1'b1;
                            state_d = S_WAIT;
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign rom_rdaddress = pc_q;
    assign out_payload   = payload_q;
    assign out_valid     = valid_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;

endmodule
`default_nettype wire

// File: tb/tb_rw_manager_m10_inst_seq.sv
`default_nettype none
// Bench for rw_manager_m10_inst_seq: directed scenarios plus random programs
// compared against a program-level interpreter of the ROM.
module tb_rw_manager_m10_inst_seq;

    localparam int MAX_ISSUES = 150;
    localparam int CYC_BUDGET = 4000;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [6:0]  start_addr = '0;
    logic [31:0] cnt_load = '0;
    logic [27:0] cnt_target = '0;
    logic [6:0]  rom_rdaddress;
    logic [19:0] rom_q;
    logic [15:0] out_payload;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        busy, done, err;

    logic [19:0] mem [128];
    logic [15:0] exp_q[$];
    logic [15:0] act_q[$];
    bit          exp_err;
    bit          model_ok;
    int          n_checks = 0;
    int          n_errors = 0;

    rw_manager_m10_inst_seq dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .start         (start),
        .start_addr    (start_addr),
        .cnt_load      (cnt_load),
        .cnt_target    (cnt_target),
        .rom_rdaddress (rom_rdaddress),
        .rom_q         (rom_q),
        .out_payload   (out_payload),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    always #5 clock = ~clock;
    always @(posedge clock) rom_q <= mem[rom_rdaddress];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start(input logic [6:0] a, input logic [31:0] ld, input logic [27:0] tg);
        start_addr = a;
        cnt_load   = ld;
        cnt_target = tg;
        start      = 1'b1;
        step();
        start      = 1'b0;
    endtask

    // Interprets the program directly: list of issued payloads and err flag.
    task automatic run_model(input logic [6:0] sa, input logic [31:0] ld, input logic [27:0] tg);
        int          pc;
        int          k;
        int          cnt [4];
        logic [19:0] w;
        logic [2:0]  j;
        exp_q.delete();
        exp_err  = 1'b0;
        model_ok = 1'b0;
        pc = int'(sa);
        for (int i = 0; i < 4; i++) cnt[i] = int'(ld[i*8 +: 8]);
        for (int s = 0; s < MAX_ISSUES; s++) begin
            w = mem[pc];
            if (w[19]) begin
                model_ok = 1'b1;
                return;
            end
            exp_q.push_back(w[15:0]);
            j = w[18:16];
            if (j >= 3'd1 && j <= 3'd4) begin
                k = int'(j) - 1;
                if (cnt[k] != 0) begin
                    cnt[k] = cnt[k] - 1;
                    pc = int'(tg[k*7 +: 7]);
                    continue;
                end
                cnt[k] = int'(ld[k*8 +: 8]);
            end
            if (pc == 127) begin
                exp_err  = 1'b1;
                model_ok = 1'b1;
                return;
            end
            pc = pc + 1;
        end
    endtask

    task automatic run_case(input string tag, input logic [6:0] sa, input logic [31:0] ld,
                            input logic [27:0] tg, input int ready_pct);
        bit          pv;
        bit          pr;
        logic [15:0] pp;
        logic [6:0]  pa;
        int          cyc;
        run_model(sa, ld, tg);
        if (!model_ok) return;
        act_q.delete();
        pv = 1'b0; pr = 1'b0; pp = '0; pa = '0; cyc = 0;
        pulse_start(sa, ld, tg);
        while (!done && cyc < CYC_BUDGET) begin
            check_eq({tag, "_busy_done_excl"}, {31'd0, busy & done}, 32'd0);
            if (pv && !pr) begin
                check_eq({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
                check_eq({tag, "_hold_payload"}, {16'd0, out_payload}, {16'd0, pp});
                check_eq({tag, "_hold_pc"}, {25'd0, rom_rdaddress}, {25'd0, pa});
            end
            out_ready = ($urandom_range(99) < ready_pct);
            if (out_valid && out_ready) act_q.push_back(out_payload);
            pv = out_valid; pr = out_ready; pp = out_payload; pa = rom_rdaddress;
            step();
            cyc++;
        end
        check_eq({tag, "_finished"}, {31'd0, done}, 32'd1);
        check_eq({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
        check_eq({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
        check_eq({tag, "_count"}, act_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
            check_eq({tag, "_payload"}, {16'd0, act_q[i]}, {16'd0, exp_q[i]});
    endtask

    initial begin
        logic [15:0] loop_exp [6];
        logic [31:0] rld;
        logic [27:0] rtg;
        logic [6:0]  rsa;
        loop_exp = '{16'h0011, 16'h0022, 16'h0011, 16'h0022, 16'h0011, 16'h0022};

        for (int i = 0; i < 128; i++) mem[i] = 20'h80000;
        mem[0] = 20'h080180;
        mem[1] = 20'h000100;
        mem[2] = 20'h080000;

        step(); step(); step();
        check_eq("rst_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_err", {31'd0, err}, 32'd0);
        check_eq("rst_addr", {25'd0, rom_rdaddress}, 32'd0);
        reset_n = 1'b1;
        step();

        // T1: reset in the middle of a handshake
        out_ready = 1'b0;
        pulse_start(7'h01, 32'd0, 28'd0);
        step(); step();
        check_eq("t1_in_issue", {31'd0, out_valid}, 32'd1);
        reset_n = 1'b0;
        step(); step();
        check_eq("t1_valid", {31'd0, out_valid}, 32'd0);
        check_eq("t1_busy", {31'd0, busy}, 32'd0);
        check_eq("t1_done", {31'd0, done}, 32'd0);
        check_eq("t1_err", {31'd0, err}, 32'd0);
        check_eq("t1_addr", {25'd0, rom_rdaddress}, 32'd0);
        reset_n = 1'b1;
        step();

        // T2: straight line with cycle-exact latency
        out_ready = 1'b1;
        pulse_start(7'h01, 32'd0, 28'd0);
        check_eq("t2_c1_busy", {31'd0, busy}, 32'd1);
        check_eq("t2_c1_addr", {25'd0, rom_rdaddress}, 32'h01);
        step();
        check_eq("t2_c2_valid", {31'd0, out_valid}, 32'd0);
        step();
        check_eq("t2_c3_valid", {31'd0, out_valid}, 32'd1);
        check_eq("t2_c3_payload", {16'd0, out_payload}, 32'h0100);
        step();
        check_eq("t2_c4_valid", {31'd0, out_valid}, 32'd0);
        step();
        check_eq("t2_c5_done", {31'd0, done}, 32'd0);
        step();
        check_eq("t2_c6_done", {31'd0, done}, 32'd1);
        check_eq("t2_c6_busy", {31'd0, busy}, 32'd0);
        check_eq("t2_c6_err", {31'd0, err}, 32'd0);

        // T3: immediate END
        pulse_start(7'h00, 32'd0, 28'd0);
        check_eq("t3_c1_done_clr", {31'd0, done}, 32'd0);
        step();
        check_eq("t3_c2_valid", {31'd0, out_valid}, 32'd0);
        step();
        check_eq("t3_c3_done", {31'd0, done}, 32'd1);
        check_eq("t3_c3_valid", {31'd0, out_valid}, 32'd0);
        check_eq("t3_c3_busy", {31'd0, busy}, 32'd0);

        // T4: loop via counter 1
        mem[7'h10] = 20'h000011;
        mem[7'h11] = 20'h020022;
        mem[7'h12] = 20'h080000;
        run_case("t4", 7'h10, 32'h0000_0200, 28'h000_0800, 100);
        check_eq("t4_len", act_q.size(), 32'd6);
        for (int i = 0; i < 6 && i < act_q.size(); i++)
            check_eq("t4_seq", {16'd0, act_q[i]}, {16'd0, loop_exp[i]});

        // T5: backpressure
        out_ready = 1'b0;
        pulse_start(7'h01, 32'd0, 28'd0);
        step(); step();
        for (int i = 0; i < 5; i++) begin
            check_eq("t5_valid", {31'd0, out_valid}, 32'd1);
            check_eq("t5_payload", {16'd0, out_payload}, 32'h0100);
            check_eq("t5_pc", {25'd0, rom_rdaddress}, 32'h01);
            step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_eq("t5_accepted", {31'd0, out_valid}, 32'd0);
        check_eq("t5_pc_adv", {25'd0, rom_rdaddress}, 32'h02);
        step(); step();
        check_eq("t5_done", {31'd0, done}, 32'd1);

        // T6: run-off at last address; start while busy is ignored
        mem[7'h7F] = 20'h000001;
        out_ready = 1'b1;
        pulse_start(7'h7F, 32'd0, 28'd0);
        start_addr = 7'h00;
        start = 1'b1;
        step();
        start = 1'b0;
        check_eq("t6_c2_addr", {25'd0, rom_rdaddress}, 32'h7F);
        check_eq("t6_c2_busy", {31'd0, busy}, 32'd1);
        step();
        check_eq("t6_c3_valid", {31'd0, out_valid}, 32'd1);
        check_eq("t6_c3_payload", {16'd0, out_payload}, 32'h0001);
        step();
        check_eq("t6_done", {31'd0, done}, 32'd1);
        check_eq("t6_err", {31'd0, err}, 32'd1);
        check_eq("t6_busy", {31'd0, busy}, 32'd0);
        step();
        check_eq("t6_no_read", {25'd0, rom_rdaddress}, 32'h7F);
        check_eq("t6_done_hold", {31'd0, done}, 32'd1);

        // Random programs with random backpressure
        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < 128; i++)
                mem[i] = {($urandom_range(7) == 0), 3'($urandom_range(7)), 16'($urandom)};
            for (int k = 0; k < 4; k++) begin
                rld[k*8 +: 8] = 8'($urandom_range(3));
                rtg[k*7 +: 7] = 7'($urandom);
            end
            rsa = 7'($urandom);
            run_case("rnd", rsa, rld, rtg, int'($urandom_range(100, 30)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
